// File: rtl/multi_click_counter_pkg.sv
// multi_click_counter_pkg
// Shared definitions for the multi-channel gated photon counter:
//   - gate_state_t  : gate FSM encoding (idle / window open / snapshot)
//   - drain_state_t : drain FSM encoding (idle / sending result words)
//   - clog2         : ceiling log2 helper usable in parameter expressions
//   - ch_width      : width of the channel index, never less than 1 bit
package multi_click_counter_pkg;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_OPEN = 2'd1,
    G_SNAP = 2'd2
  } gate_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_SEND = 1'b1
  } drain_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/click_channel.sv
// click_channel
// One detector channel: 2-flop synchroniser, edge register, saturating
// counter with a sticky overflow bit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   count_in   : asynchronous click input
//   en_d       : gate, already delayed to line up with the synchronised click
//   clear      : restart the count for a new gate (same-cycle click still counts)
//   count      : current count, saturates at all-ones
//   ovf        : set when an increment is attempted at the maximum count
module click_channel #(
  parameter int CNT_WIDTH = 24,
  parameter int EDGE_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 count_in,
  input  logic                 en_d,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic sync1;
  logic sync;
  logic sync_prev;
  logic inc;

  // Synchroniser plus the previous-value register used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= count_in;
      sync      <= sync1;
      sync_prev <= sync;
    end
  end

  assign inc = (EDGE_MODE != 0) ? (sync & ~sync_prev & en_d) : (sync & en_d);

  // A clear loads 0 or 1 so a click arriving on the gate's first cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= CNT_WIDTH'(inc);
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == CNT_MAX) ovf <= 1'b1;
      else                  count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multi_click_counter.sv
// multi_click_counter
// Multi-channel gated photon counter. Clicks on NUM_CH inputs are counted
// while count_enable is high; at gate end the counts are snapshotted and
// drained one channel per word over a valid/ack handshake.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   count_in        : asynchronous click inputs, bit i = channel i
//   count_enable    : gate window (synchronous to clk)
//   counter_id      : tag latched at gate start
//   result_valid    : result word available
//   result_ack      : consumer accepts current word
//   result_data     : count for result_ch
//   result_ch       : channel index of the current word
//   result_id       : tag of the gate the word belongs to
//   result_overflow : channel saturated during that gate
//   gate_dropped    : one-cycle pulse when a gate ended while a drain was busy
module multi_click_counter
  import multi_click_counter_pkg::*;
#(
  parameter  int NUM_CH    = 8,
  parameter  int CNT_WIDTH = 24,
  parameter  int ID_WIDTH  = 8,
  parameter  int EDGE_MODE = 1,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    count_in,
  input  logic                 count_enable,
  input  logic [ID_WIDTH-1:0]  counter_id,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic [CNT_WIDTH-1:0] result_data,
  output logic [CH_W-1:0]      result_ch,
  output logic [ID_WIDTH-1:0]  result_id,
  output logic                 result_overflow,
  output logic                 gate_dropped
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  gate_state_t  g_state, g_next;
  drain_state_t d_state, d_next;

  logic                 en_s1;
  logic                 en_d;
  logic                 clear;
  logic                 snap;
  logic                 drop;
  logic [ID_WIDTH-1:0]  id_q;
  logic [CH_W-1:0]      idx, idx_next;

  logic [CNT_WIDTH-1:0] count [NUM_CH];
  logic [NUM_CH-1:0]    ovf;
  logic [CNT_WIDTH-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0]    shadow_ovf;
  logic [ID_WIDTH-1:0]  shadow_id;

  // The gate gets the same two-flop delay as the clicks so both stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1 <= 1'b0;
      en_d  <= 1'b0;
    end else begin
      en_s1 <= count_enable;
      en_d  <= en_s1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    click_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_in (count_in[i]),
      .en_d     (en_d),
      .clear    (clear),
      .count    (count[i]),
      .ovf      (ovf[i])
    );
  end

  // State, tag, shadow and drop-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_state      <= G_IDLE;
      d_state      <= D_IDLE;
      idx          <= '0;
      id_q         <= '0;
      shadow_id    <= '0;
      shadow_ovf   <= '0;
      gate_dropped <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      g_state      <= g_next;
      d_state      <= d_next;
      idx          <= idx_next;
      gate_dropped <= drop;
      if (clear) id_q <= counter_id;
      if (snap) begin
        shadow_id  <= id_q;
        shadow_ovf <= ovf;
        for (int i = 0; i < NUM_CH; i++) shadow[i] <= count[i];
      end
    end
  end

  // Gate FSM: a snapshot is only taken if the drain side is free; otherwise
  // the gate is discarded and reported.
  always_comb begin
    g_next = g_state;
    clear  = 1'b0;
    snap   = 1'b0;
    drop   = 1'b0;
    case (g_state)
      G_IDLE: begin
        if (en_d) begin
          clear  = 1'b1;
          g_next = G_OPEN;
        end
      end
      G_OPEN: begin
        if (!en_d) g_next = G_SNAP;
      end
      G_SNAP: begin
        g_next = G_IDLE;
        if (d_state == D_IDLE) snap = 1'b1;
        else                   drop = 1'b1;
      end
      default: g_next = G_IDLE;
    endcase
  end

  // Drain FSM: one word per accepted ack, back-to-back while ack is held.
  always_comb begin
    d_next   = d_state;
    idx_next = idx;
    case (d_state)
      D_IDLE: begin
        if (snap) begin
          d_next   = D_SEND;
          idx_next = '0;
        end
      end
      D_SEND: begin
        if (result_ack) begin
          if (idx == LAST_CH) d_next   = D_IDLE;
          else                idx_next = idx + 1'b1;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  assign result_valid    = (d_state == D_SEND);
  assign result_data     = result_valid ? shadow[idx]     : '0;
  assign result_ch       = result_valid ? idx             : '0;
  assign result_id       = result_valid ? shadow_id       : '0;
  assign result_overflow = result_valid ? shadow_ovf[idx] : 1'b0;

endmodule

// File: tb/tb_multi_click_counter.sv
// tb_multi_click_counter
// Three instances share one stimulus stream: edge mode with wide counters,
// level mode, and edge mode with 4-bit counters that saturate.
module tb_multi_click_counter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  count_in;
  logic        count_enable;
  logic [7:0]  counter_id;
  logic        result_ack;

  logic        e_valid, l_valid, s_valid;
  logic [23:0] e_data;
  logic [7:0]  l_data;
  logic [3:0]  s_data;
  logic [1:0]  e_ch, l_ch, s_ch;
  logic [7:0]  e_id, l_id, s_id;
  logic        e_ovf, l_ovf, s_ovf;
  logic        e_drop, l_drop, s_drop;

  int checks;
  int errors;
  int e_drops, l_drops, s_drops;

  int exp_e[4], exp_l[4], exp_s[4];
  int exp_oe[4], exp_ol[4], exp_os[4];
  logic [7:0] exp_id;

  multi_click_counter #(.NUM_CH(4), .CNT_WIDTH(24), .ID_WIDTH(8), .EDGE_MODE(1)) dut_edge (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_enable(count_enable),
    .counter_id(counter_id), .result_valid(e_valid), .result_ack(result_ack),
    .result_data(e_data), .result_ch(e_ch), .result_id(e_id),
    .result_overflow(e_ovf), .gate_dropped(e_drop)
  );

  multi_click_counter #(.NUM_CH(4), .CNT_WIDTH(8), .ID_WIDTH(8), .EDGE_MODE(0)) dut_level (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_enable(count_enable),
    .counter_id(counter_id), .result_valid(l_valid), .result_ack(result_ack),
    .result_data(l_data), .result_ch(l_ch), .result_id(l_id),
    .result_overflow(l_ovf), .gate_dropped(l_drop)
  );

  multi_click_counter #(.NUM_CH(4), .CNT_WIDTH(4), .ID_WIDTH(8), .EDGE_MODE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .count_in(count_in), .count_enable(count_enable),
    .counter_id(counter_id), .result_valid(s_valid), .result_ack(result_ack),
    .result_data(s_data), .result_ch(s_ch), .result_id(s_id),
    .result_overflow(s_ovf), .gate_dropped(s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count gate_dropped pulses per instance.
  always @(negedge clk) begin
    if (e_drop) e_drops++;
    if (l_drop) l_drops++;
    if (s_drop) s_drops++;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      $error("[TB] %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge.
  task automatic apply_stimulus(input logic en, input logic [3:0] clicks);
    @(negedge clk);
    count_enable = en;
    count_in     = clicks;
  endtask

  task automatic check_word(input int w);
    check_output($sformatf("edge valid w%0d", w),  32'(e_valid), 32'd1);
    check_output($sformatf("edge data w%0d", w),   32'(e_data),  32'(exp_e[w]));
    check_output($sformatf("edge ch w%0d", w),     32'(e_ch),    32'(w));
    check_output($sformatf("edge id w%0d", w),     32'(e_id),    32'(exp_id));
    check_output($sformatf("edge ovf w%0d", w),    32'(e_ovf),   32'(exp_oe[w]));
    check_output($sformatf("level valid w%0d", w), 32'(l_valid), 32'd1);
    check_output($sformatf("level data w%0d", w),  32'(l_data),  32'(exp_l[w]));
    check_output($sformatf("level ch w%0d", w),    32'(l_ch),    32'(w));
    check_output($sformatf("level id w%0d", w),    32'(l_id),    32'(exp_id));
    check_output($sformatf("level ovf w%0d", w),   32'(l_ovf),   32'(exp_ol[w]));
    check_output($sformatf("sat valid w%0d", w),   32'(s_valid), 32'd1);
    check_output($sformatf("sat data w%0d", w),    32'(s_data),  32'(exp_s[w]));
    check_output($sformatf("sat ch w%0d", w),      32'(s_ch),    32'(w));
    check_output($sformatf("sat id w%0d", w),      32'(s_id),    32'(exp_id));
    check_output($sformatf("sat ovf w%0d", w),     32'(s_ovf),   32'(exp_os[w]));
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, " valid"}, {29'd0, e_valid, l_valid, s_valid}, 32'd0);
    check_output({tag, " data"},  32'(e_data) | 32'(l_data) | 32'(s_data), 32'd0);
    check_output({tag, " ch/id"}, {16'd0, e_ch, l_ch, s_ch, 2'd0, e_id | l_id | s_id}, 32'd0);
    check_output({tag, " ovf/drop"}, {26'd0, e_ovf, l_ovf, s_ovf, e_drop, l_drop, s_drop}, 32'd0);
  endtask

  // With word 0 visible at a falling edge, accept all four words back-to-back.
  task automatic drain_all();
    for (int w = 0; w < 4; w++) begin
      check_word(w);
      result_ack = 1'b1;
      @(negedge clk);
    end
    check_output("valid after last word", {29'd0, e_valid, l_valid, s_valid}, 32'd0);
    result_ack = 1'b0;
  endtask

  // Main gate pattern: ch0 5 pulses, ch1 held 50 clocks, ch2 17 pulses, ch3 20 pulses.
  function automatic logic [3:0] main_clicks(input int t);
    logic [3:0] c;
    c    = 4'b0000;
    c[0] = (t < 20) && (t % 4 == 2);
    c[1] = (t >= 120) && (t < 170);
    c[2] = (t >= 40) && (t < 108) && (t % 4 == 0);
    c[3] = (t >= 150) && (t < 190) && (t % 2 == 1);
    return c;
  endfunction

  // Short gate pattern: ch0 pulses at t=1,3,5; ch1 pulse at t=2.
  function automatic logic [3:0] short_clicks(input int t);
    logic [3:0] c;
    c    = 4'b0000;
    c[0] = (t == 1) || (t == 3) || (t == 5);
    c[1] = (t == 2);
    return c;
  endfunction

  initial begin
    checks       = 0;
    errors       = 0;
    e_drops      = 0;
    l_drops      = 0;
    s_drops      = 0;
    rst_n        = 1'b0;
    count_in     = 4'b0000;
    count_enable = 1'b0;
    counter_id   = 8'h00;
    result_ack   = 1'b0;

    // Reset state and idle behaviour.
    repeat (3) @(negedge clk);
    check_idle("in reset");
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_output("idle valid", {29'd0, e_valid, l_valid, s_valid}, 32'd0);
    end

    // Long gate covering edge, level and saturation counting.
    $display("[TB] long gate, id 0x3C");
    exp_e  = '{5, 1, 17, 20};
    exp_l  = '{5, 50, 17, 20};
    exp_s  = '{5, 1, 15, 15};
    exp_oe = '{0, 0, 0, 0};
    exp_ol = '{0, 0, 0, 0};
    exp_os = '{0, 0, 1, 1};
    exp_id = 8'h3C;
    counter_id = 8'h3C;
    for (int t = 0; t < 200; t++) apply_stimulus(1'b1, main_clicks(t));
    apply_stimulus(1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    check_output("valid 3 clocks after gate fall", {29'd0, e_valid, l_valid, s_valid}, 32'd0);
    @(negedge clk);
    check_word(0);

    // Backpressure: word 0 must hold while ack is low.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_word(0);
    end
    drain_all();
    check_output("no drops after long gate", 32'(e_drops + l_drops + s_drops), 32'd0);

    // Short gate, then a second gate that ends while the first drain is stalled.
    $display("[TB] dropped gate while drain stalled");
    exp_e  = '{3, 1, 0, 0};
    exp_l  = '{3, 1, 0, 0};
    exp_s  = '{3, 1, 0, 0};
    exp_os = '{0, 0, 0, 0};
    exp_id = 8'hA5;
    counter_id = 8'hA5;
    for (int t = 0; t < 10; t++) apply_stimulus(1'b1, short_clicks(t));
    apply_stimulus(1'b0, 4'b0000);
    repeat (4) @(negedge clk);
    check_word(0);
    counter_id = 8'h11;
    apply_stimulus(1'b1, 4'b1111);
    apply_stimulus(1'b0, 4'b0000);
    repeat (10) @(negedge clk);
    check_output("edge drop pulses",  32'(e_drops), 32'd1);
    check_output("level drop pulses", 32'(l_drops), 32'd1);
    check_output("sat drop pulses",   32'(s_drops), 32'd1);
    drain_all();
    repeat (20) @(negedge clk);
    check_output("no drain for dropped gate", {29'd0, e_valid, l_valid, s_valid}, 32'd0);
    check_output("drop pulses unchanged", 32'(e_drops + l_drops + s_drops), 32'd3);

    // One-clock gate with a click on its only cycle, then reset mid-drain.
    $display("[TB] single-cycle gate and async reset");
    exp_e  = '{1, 0, 0, 0};
    exp_l  = '{1, 0, 0, 0};
    exp_s  = '{1, 0, 0, 0};
    exp_id = 8'h77;
    counter_id = 8'h77;
    apply_stimulus(1'b1, 4'b0001);
    apply_stimulus(1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    check_output("single gate valid early", {29'd0, e_valid, l_valid, s_valid}, 32'd0);
    @(negedge clk);
    check_word(0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("after reset release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
